// File: rtl/knn_nat_master.sv
// knn_nat_master
// Native-bus initiator for the KNN peripheral's CPU slave port. A sequencer
// or harness feeds commands into a small FIFO. A three-state request FSM
// (IDLE -> REQ -> GAP) replays each command on the native bus.
// When a read completes or any transaction times out, a one-cycle response
// pulse is produced.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   command stream handshake (cmd_ready = FIFO not full)
//   cmd_write/addr/wdata  command payload (wdata ignored on reads)
//   rsp_valid/rdata/err   response pulse, read data, timeout qualifier
//   busy              FIFO non-empty or FSM not IDLE
//   err / err_clr     sticky timeout flag and its clear
//   m_valid/address/wdata/wstrb  native request to the slave
//   m_rdata/m_ready   native response from the slave
//   dbg_state         current FSM state (IDLE=0, REQ=1, GAP=2)
//
// Handshake: a command transfers on any rising edge with cmd_valid & cmd_ready.
// A native transfer completes on any edge where m_valid & m_ready. The request
// fields hold steady for as long as m_valid is high. rsp_valid is a pulse with
// no back-pressure.
module knn_nat_master #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int FIFO_AW = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr,
  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ready,
  output logic [1:0]            dbg_state
);

  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int STRB_W = DATA_W / 8;
  localparam int TCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_GAP = 2'd2} state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // FIFO
  cmd_t               mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               push, pop;
  cmd_t               head;

  // FSM and registered outputs
  state_e             state_q, state_d;
  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  logic               is_write_q, is_write_d;
  logic               m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]  m_address_q, m_address_d;
  logic [DATA_W-1:0]  m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0]  m_wstrb_q, m_wstrb_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               err_q, err_d;
  logic               timeout;

  // Depth is a power of two, so the count MSB is set exactly when full.
  // cmd_ready looks only at the registered count, so a pop in this cycle
  // does not reopen the FIFO until the next cycle.
  assign cmd_ready = ~count_q[FIFO_AW];
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    is_write_d  = is_write_q;
    m_valid_d   = m_valid_q;
    m_address_d = m_address_q;
    m_wdata_d   = m_wdata_q;
    m_wstrb_d   = m_wstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
    pop         = 1'b0;
    timeout     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          state_d     = S_REQ;
          tcnt_d      = '0;
          is_write_d  = head.write;
          m_valid_d   = 1'b1;
          m_address_d = head.addr;
          m_wdata_d   = head.write ? head.wdata : '0;
          m_wstrb_d   = head.write ? '1 : '0;
        end
      end
      S_REQ: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = S_GAP;
          if (!is_write_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = m_rdata;
          end
        end else if (tcnt_q == TCNT_LAST) begin
          timeout     = 1'b1;
          m_valid_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = S_GAP;
        end else begin
          // Below TCNT_LAST here, so the counter cannot wrap.
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      // One dead cycle lets the slave's registered ready fall before
      // the next request.
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A timeout in the same cycle as err_clr keeps the flag set.
    if (timeout)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;

    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tcnt_q      <= '0;
      is_write_q  <= 1'b0;
      m_valid_q   <= 1'b0;
      m_address_q <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tcnt_q      <= tcnt_d;
      is_write_q  <= is_write_d;
      m_valid_q   <= m_valid_d;
      m_address_q <= m_address_d;
      m_wdata_q   <= m_wdata_d;
      m_wstrb_q   <= m_wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_q       <= err_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_address = m_address_q;
  assign m_wdata   = m_wdata_q;
  assign m_wstrb   = m_wstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign err       = err_q;
  assign busy      = (count_q != '0) | (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule
